blink_core_scheduler: RTL
=========================

// Module: blink_core_scheduler
// PURPOSE
// - Shares one combinational 64-bit Blink core (enc, K0[447:0], P, T -> C) between NREQ requesters.
// - Holds the master key, arbitrates requests round-robin and registers the core inputs.
// - Holds those inputs stable for SETTLE_CYCLES clocks (multicycle path), captures C and returns it tagged with the requester id.
// PARAMETERS
// - NREQ          2    number of requesters (>=2)
// - SETTLE_CYCLES 3    clocks core inputs are held before C is sampled (>=1)
// - BLK_W         64   block/tweak width; fixed to the core width
// - KEY_W         448  master key width (7*BLK_W)
// PORTS
// - clk        in   1            single clock, rising edge
// - rst        in   1            synchronous, active-high reset
// - key_load   in   1            load key_in into key register
// - key_in     in   KEY_W        master key K0
// - key_ready  out  1            key load accepted this cycle
// - req_valid  in   NREQ         per-requester request
// - req_ready  out  NREQ         one-hot grant; handshake = valid&ready
// - req_enc    in   NREQ         1=encrypt, 0=decrypt
// - req_data   in   NREQ*BLK_W   plaintext/ciphertext, requester i at [i*BLK_W +: BLK_W]
// - req_tweak  in   NREQ*BLK_W   tweak, same packing
// - rsp_valid  out  1            result available
// - rsp_ready  in   1            result consumed
// - rsp_id     out  $clog2(NREQ) requester index of result
// - rsp_data   out  BLK_W        core output C
// - core_enc   out  1            to core enc
// - core_key   out  KEY_W        to core K0 (= key register)
// - core_p     out  BLK_W        to core P
// - core_t     out  BLK_W        to core T
// - core_c     in   BLK_W        from core C
// BEHAVIOUR
// - Reset (sync): state=IDLE, key_valid=0, rr pointer=0, cnt=0.
// - Reset values of outputs and registers: rsp_valid=0, rsp_id=0, rsp_data=0, core_enc/core_key/core_p/core_t=0.
// - Reset mid-operation aborts the in-flight job; no response is produced.
// - FSM states: IDLE -> BUSY -> RESP -> IDLE.
// - key_ready = (state==IDLE). A key_load in IDLE writes the key register and sets key_valid. key_load outside IDLE is ignored.
// - IDLE arbitration: req_ready = rr_grant(req_valid) only when key_valid && !key_load; otherwise all zero. key_load wins over requests in the same cycle.
// - Round robin: search starts at pointer p. On a grant to index g, p <= (g+1) mod NREQ. A requester dropping valid before it is granted is legal.
// - Accept edge (IDLE, some valid&ready): core_enc/core_p/core_t <= granted requester's fields; rsp_id <= g; cnt <= SETTLE_CYCLES-1; state <= BUSY.
// - BUSY: core_* registers are frozen. On each edge, if cnt!=0 then cnt--. Else rsp_data <= core_c, rsp_valid <= 1, state <= RESP.
// - Latency: rsp_valid rises exactly SETTLE_CYCLES edges after the accept edge.
// - RESP: rsp_valid, rsp_id and rsp_data are held stable until rsp_ready. On valid&ready: rsp_valid <= 0, state <= IDLE.
// - Next grant is possible in the cycle after the response handshake. Minimum spacing between accepts is SETTLE_CYCLES+2 cycles.
// - core_key always equals the key register. The key cannot change while BUSY or RESP.
// - No requests are granted before the first key load after reset.
// STRUCTURE
// - Shared package blink_pkg: BLK_W, KEY_W, state enum {IDLE,BUSY,RESP}.
// - One sub-module, blink_rr_arbiter #(NREQ): combinational one-hot grant from req/pointer, plus grant index output.
// - The Blink core is instantiated beside this block and connected through the core_* ports.
// TESTING
// - Requests before key load: req_valid=2'b11, no key load -> req_ready=0 for 20 cycles; no rsp_valid.
// - Single job, SETTLE=3: load key, req0 enc=1 P=64'h0123456789abcdef T=0 accepted at E0 -> rsp_valid after E3.
//   Required: rsp_id=0 and rsp_data equal to the reference-model C. core_p is stable from E0 to E3.
// - Fairness: req_valid=2'b11 held, rsp_ready=1 -> grants alternate 0,1,0,1 over 8 jobs, each spaced 5 cycles.
// - Backpressure: rsp_ready=0 for 10 cycles -> rsp_valid, rsp_id and rsp_data are constant; req_ready=0. Releasing rsp_ready returns to IDLE in 1 cycle.
// - Same-cycle collision: key_load=1 with req_valid=2'b01 in IDLE -> key loaded, req_ready=0. Request granted the next cycle using the new key.
// - Reset in BUSY (cnt=1): rst pulse -> rsp_valid=0, key_valid=0, pointer=0. No response emitted; requests are blocked until a key reload.

Source files
------------

// File: rtl/blink_pkg.sv
//------------------------------------------------------------------------------
// Module   : blink_pkg
// Purpose  : Shared widths and scheduler state encoding for the Blink core
//            scheduler slice.
// Contents : BLK_W   - block/tweak width of the Blink core (64)
//            KEY_W   - master key width, seven blocks (448)
//            state_t - scheduler FSM states IDLE/BUSY/RESP
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package blink_pkg;

  localparam int BLK_W = 64;
  localparam int KEY_W = 7 * BLK_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage : blink_pkg

`default_nettype wire

// File: rtl/blink_rr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : blink_rr_arbiter
// Purpose  : Combinational round-robin arbiter. Searches the request vector
//            starting at the pointer position and returns the first active
//            requester as a one-hot grant plus its binary index.
// Ports    : i_req   [NREQ]        request vector
//            i_ptr   [$clog2(NREQ)] search start position (< NREQ)
//            o_grant [NREQ]        one-hot grant (all zero when no request)
//            o_idx   [$clog2(NREQ)] index of the granted requester
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module blink_rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_ptr,
  output logic [NREQ-1:0]         o_grant,
  output logic [$clog2(NREQ)-1:0] o_idx
);

  localparam int IDX_W = $clog2(NREQ);

  // One extra bit so ptr+k never wraps before the modulo correction.
  logic [IDX_W:0] w_pos;
  logic           w_found;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_pos   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_pos = {1'b0, i_ptr} + (IDX_W+1)'(k);
      if (w_pos >= (IDX_W+1)'(NREQ)) begin
        w_pos = w_pos - (IDX_W+1)'(NREQ);
      end
      if (!w_found && i_req[w_pos[IDX_W-1:0]]) begin
        w_found                   = 1'b1;
        o_grant[w_pos[IDX_W-1:0]] = 1'b1;
        o_idx                     = w_pos[IDX_W-1:0];
      end
    end
  end

endmodule : blink_rr_arbiter

`default_nettype wire

// File: rtl/blink_core_scheduler.sv
//------------------------------------------------------------------------------
// Module   : blink_core_scheduler
// Purpose  : Shares one combinational 64-bit Blink core between NREQ
//            requesters. Holds the master key, grants requests round-robin,
//            registers the core inputs, holds them for SETTLE_CYCLES clocks
//            (multicycle path into the core), then captures C and returns it
//            tagged with the requester id.
// Ports    : clk, rst                 clock, synchronous active-high reset
//            key_load/key_in/key_ready master key load (accepted in IDLE)
//            req_valid/req_ready      per-requester handshake, one-hot grant
//            req_enc/req_data/req_tweak packed request fields
//            rsp_valid/rsp_ready      result handshake
//            rsp_id/rsp_data          requester index and core output
//            core_enc/core_key/core_p/core_t  registered core inputs
//            core_c                   core output
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module blink_core_scheduler
  import blink_pkg::*;
#(
  parameter int NREQ          = 2,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key_load,
  input  logic [KEY_W-1:0]        key_in,
  output logic                    key_ready,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ-1:0]         req_enc,
  input  logic [NREQ*BLK_W-1:0]   req_data,
  input  logic [NREQ*BLK_W-1:0]   req_tweak,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [BLK_W-1:0]        rsp_data,
  output logic                    core_enc,
  output logic [KEY_W-1:0]        core_key,
  output logic [BLK_W-1:0]        core_p,
  output logic [BLK_W-1:0]        core_t,
  input  logic [BLK_W-1:0]        core_c
);

  localparam int ID_W  = $clog2(NREQ);
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ID_W-1:0]  c_last_id  = ID_W'(NREQ - 1);

  state_t            r_state;
  logic              r_key_valid;
  logic [KEY_W-1:0]  r_key;
  logic [ID_W-1:0]   r_ptr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_rsp_valid;
  logic [ID_W-1:0]   r_rsp_id;
  logic [BLK_W-1:0]  r_rsp_data;
  logic              r_core_enc;
  logic [BLK_W-1:0]  r_core_p;
  logic [BLK_W-1:0]  r_core_t;

  logic [NREQ-1:0]   w_grant;
  logic [ID_W-1:0]   w_gidx;
  logic              w_arb_en;
  logic              w_accept;

  blink_rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gidx)
  );

  // A key load in the same cycle takes priority, so no grant is offered then.
  assign w_arb_en  = (r_state == IDLE) && r_key_valid && !key_load;
  assign req_ready = w_arb_en ? w_grant : '0;
  assign w_accept  = |(req_valid & req_ready);
  assign key_ready = (r_state == IDLE);

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign core_enc  = r_core_enc;
  assign core_key  = r_key;
  assign core_p    = r_core_p;
  assign core_t    = r_core_t;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_key_valid <= 1'b0;
      r_key       <= '0;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_core_enc  <= 1'b0;
      r_core_p    <= '0;
      r_core_t    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (key_load) begin
            r_key       <= key_in;
            r_key_valid <= 1'b1;
          end else if (w_accept) begin
            r_core_enc <= req_enc[w_gidx];
            r_core_p   <= req_data[w_gidx*BLK_W +: BLK_W];
            r_core_t   <= req_tweak[w_gidx*BLK_W +: BLK_W];
            r_rsp_id   <= w_gidx;
            r_cnt      <= c_cnt_load;
            r_ptr      <= (w_gidx == c_last_id) ? '0 : w_gidx + ID_W'(1);
            r_state    <= BUSY;
          end
        end
        BUSY: begin
          // Core inputs are frozen here; C is sampled once the count expires.
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_rsp_data  <= core_c;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule : blink_core_scheduler

`default_nettype wire
